// File: rtl/asteroids_pkg.sv
// Shared types, constants and helpers for the asteroid wave controller.
package asteroids_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUNNING,
        S_DRAINING,
        S_DONE,
        S_FAILED
    } wave_state_t;

    localparam int unsigned CNT_W     = 8;
    localparam logic [7:0]  LFSR_SEED = 8'hA5;
    // Feedback taps at bits 7, 5, 4 and 3
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
        return n;
    endfunction

    // Saturating add used by the hit/escape counters
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/asteroids_wave_controller_if.sv
// Controller <-> asteroid mover bus: spawn commands out, hit/exit reports back.
interface asteroids_wave_controller_if #(
    parameter int unsigned NUM_SLOTS   = 4,
    parameter int unsigned PIXEL_WIDTH = 11
);
    logic [NUM_SLOTS-1:0]   asteroid_hit;
    logic [NUM_SLOTS-1:0]   asteroid_exited;
    logic [NUM_SLOTS-1:0]   slot_active;
    logic [NUM_SLOTS-1:0]   spawn_pulse;
    logic [PIXEL_WIDTH-1:0] spawn_y;

    modport master (
        input  asteroid_hit, asteroid_exited,
        output slot_active, spawn_pulse, spawn_y
    );

    modport slave (
        output asteroid_hit, asteroid_exited,
        input  slot_active, spawn_pulse, spawn_y
    );
endinterface

// File: rtl/asteroid_slot_picker.sv
// Priority picker: lowest-index free slot as flag, one-hot select and index.
module asteroid_slot_picker #(
    parameter  int unsigned NUM_SLOTS = 4,
    localparam int unsigned IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic [NUM_SLOTS-1:0] free_mask,
    output logic                 found_c,
    output logic [NUM_SLOTS-1:0] onehot_c,
    output logic [IDX_W-1:0]     index_c
);
    always_comb begin
        found_c  = 1'b0;
        onehot_c = '0;
        index_c  = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (free_mask[i] && !found_c) begin
                found_c     = 1'b1;
                onehot_c[i] = 1'b1;
                index_c     = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/asteroids_wave_controller.sv
// Schedules one asteroid wave: launches slots on a frame cadence, counts hits/escapes, reports outcome.
module asteroids_wave_controller
    import asteroids_pkg::*;
#(
    parameter int unsigned NUM_SLOTS      = 4,
    parameter int unsigned SPAWN_INTERVAL = 45,
    parameter int unsigned WAVE_SIZE      = 12,
    parameter int unsigned MAX_ESCAPES    = 3,
    parameter int unsigned Y_MIN          = 32,
    parameter int unsigned PIXEL_WIDTH    = 11
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 stage_enable,
    asteroids_wave_controller_if.master mov,
    output logic [CNT_W-1:0]     destroyed_count,
    output logic [CNT_W-1:0]     escaped_count,
    output logic                 stage_done,
    output logic                 stage_failed
);
    localparam int unsigned IDX_W        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [CNT_W-1:0] FRAME_RELOAD = CNT_W'(SPAWN_INTERVAL - 1);

    wave_state_t            state_q, state_d;
    logic [CNT_W-1:0]       frame_q, frame_d;
    logic [7:0]             lfsr_q, lfsr_d;
    logic [CNT_W-1:0]       spawned_q, spawned_d;
    logic [NUM_SLOTS-1:0]   active_q, active_d;
    logic [NUM_SLOTS-1:0]   pulse_q, pulse_d;
    logic [PIXEL_WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0]       destroyed_q, destroyed_d;
    logic [CNT_W-1:0]       escaped_q, escaped_d;
    logic                   done_q, done_d;
    logic                   failed_q, failed_d;
    logic                   go_idle;

    logic                   pick_found;
    logic [NUM_SLOTS-1:0]   pick_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic [NUM_SLOTS-1:0]   set_mask;
    logic [NUM_SLOTS-1:0]   hits;
    logic [NUM_SLOTS-1:0]   exits;

    // A simultaneous hit and exit on one slot counts as a hit only
    assign hits     = active_q & mov.asteroid_hit;
    assign exits    = active_q & mov.asteroid_exited & ~mov.asteroid_hit;
    assign set_mask = NUM_SLOTS'(1) << pick_idx;

    asteroid_slot_picker #(.NUM_SLOTS(NUM_SLOTS)) u_picker (
        .free_mask (~active_q),
        .found_c   (pick_found),
        .onehot_c  (pick_onehot),
        .index_c   (pick_idx)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= S_IDLE;
            frame_q     <= '0;
            lfsr_q      <= LFSR_SEED;
            spawned_q   <= '0;
            active_q    <= '0;
            pulse_q     <= '0;
            y_q         <= '0;
            destroyed_q <= '0;
            escaped_q   <= '0;
            done_q      <= 1'b0;
            failed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            lfsr_q      <= lfsr_d;
            spawned_q   <= spawned_d;
            active_q    <= active_d;
            pulse_q     <= pulse_d;
            y_q         <= y_d;
            destroyed_q <= destroyed_d;
            escaped_q   <= escaped_d;
            done_q      <= done_d;
            failed_q    <= failed_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        lfsr_d      = lfsr_q;
        spawned_d   = spawned_q;
        active_d    = active_q;
        pulse_d     = '0;
        y_d         = y_q;
        destroyed_d = destroyed_q;
        escaped_d   = escaped_q;
        done_d      = 1'b0;
        failed_d    = 1'b0;
        go_idle     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (stage_enable) begin
                    state_d     = S_RUNNING;
                    frame_d     = '0;
                    lfsr_d      = LFSR_SEED;
                    spawned_d   = '0;
                    destroyed_d = '0;
                    escaped_d   = '0;
                end
            end
            S_RUNNING, S_DRAINING: begin
                if (!stage_enable) begin
                    go_idle = 1'b1;
                end else if (escaped_q >= CNT_W'(MAX_ESCAPES)) begin
                    state_d  = S_FAILED;
                    failed_d = 1'b1;
                    active_d = '0;
                end else begin
                    active_d    = active_q & ~(hits | exits);
                    destroyed_d = sat_add(destroyed_q, popcount8(8'(hits)));
                    escaped_d   = sat_add(escaped_q, popcount8(8'(exits)));
                    if (state_q == S_DRAINING) begin
                        if (active_q == '0) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end else if (spawned_q == CNT_W'(WAVE_SIZE)) begin
                        state_d = S_DRAINING;
                    end else if (startOfFrame) begin
                        // Counter parks at zero while no slot is free, retrying each frame
                        if (frame_q != '0) begin
                            frame_d = frame_q - CNT_W'(1);
                        end else if (pick_found) begin
                            active_d  = active_d | set_mask;
                            pulse_d   = pick_onehot;
                            y_d       = PIXEL_WIDTH'(Y_MIN) + PIXEL_WIDTH'(lfsr_q);
                            lfsr_d    = lfsr_next(lfsr_q);
                            spawned_d = spawned_q + CNT_W'(1);
                            frame_d   = FRAME_RELOAD;
                        end
                    end
                end
            end
            S_DONE: begin
                if (!stage_enable) go_idle = 1'b1;
                else               done_d  = 1'b1;
            end
            S_FAILED: begin
                if (!stage_enable) go_idle  = 1'b1;
                else               failed_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (go_idle) begin
            state_d     = S_IDLE;
            frame_d     = '0;
            lfsr_d      = LFSR_SEED;
            spawned_d   = '0;
            active_d    = '0;
            y_d         = '0;
            destroyed_d = '0;
            escaped_d   = '0;
        end
    end

    assign mov.slot_active = active_q;
    assign mov.spawn_pulse = pulse_q;
    assign mov.spawn_y     = y_q;
    assign destroyed_count = destroyed_q;
    assign escaped_count   = escaped_q;
    assign stage_done      = done_q;
    assign stage_failed    = failed_q;
endmodule

// File: tb/tb_asteroids_wave_controller.sv
// Scoreboard bench: directed wave scenarios plus random traffic against a frame-level reference model.
module tb_asteroids_wave_controller;
    localparam int NS = 4;
    localparam int SI = 3;
    localparam int WS = 6;
    localparam int ME = 2;
    localparam int YM = 32;
    localparam int PW = 11;

    logic clk;
    logic resetN;
    logic startOfFrame;
    logic stage_enable;
    logic [7:0] destroyed_count;
    logic [7:0] escaped_count;
    logic stage_done;
    logic stage_failed;

    asteroids_wave_controller_if #(.NUM_SLOTS(NS), .PIXEL_WIDTH(PW)) bus ();

    asteroids_wave_controller #(
        .NUM_SLOTS(NS), .SPAWN_INTERVAL(SI), .WAVE_SIZE(WS),
        .MAX_ESCAPES(ME), .Y_MIN(YM), .PIXEL_WIDTH(PW)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .stage_enable    (stage_enable),
        .mov             (bus),
        .destroyed_count (destroyed_count),
        .escaped_count   (escaped_count),
        .stage_done      (stage_done),
        .stage_failed    (stage_failed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { int slot; int y; } spawn_t;
    spawn_t exp_q[$];

    // Reference model: wave phase, live slots and tallies
    typedef enum int { PH_OFF, PH_WAVE, PH_DRAIN, PH_WON, PH_LOST } phase_t;
    phase_t     ph;
    bit         m_live [NS];
    int         m_dest, m_esc, m_launched, m_wait, m_y;
    logic [7:0] lfsr_tab [256];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int live_mask();
        int m = 0;
        for (int i = 0; i < NS; i++) if (m_live[i]) m += (1 << i);
        return m;
    endfunction

    task automatic model_clear();
        ph = PH_OFF;
        for (int i = 0; i < NS; i++) m_live[i] = 1'b0;
        m_dest = 0; m_esc = 0; m_launched = 0; m_wait = 0; m_y = 0;
    endtask

    task automatic model_step(input bit sof, input bit en, input logic [3:0] h, input logic [3:0] x);
        bit old [NS];
        int nh, ne, slot;
        case (ph)
            PH_OFF: if (en) begin
                ph = PH_WAVE; m_wait = 0; m_launched = 0; m_dest = 0; m_esc = 0;
            end
            PH_WAVE, PH_DRAIN: begin
                if (!en) model_clear();
                else if (m_esc >= ME) begin
                    ph = PH_LOST;
                    for (int i = 0; i < NS; i++) m_live[i] = 1'b0;
                end else begin
                    old = m_live; nh = 0; ne = 0;
                    for (int i = 0; i < NS; i++) begin
                        if (old[i] && h[i])      begin nh++; m_live[i] = 1'b0; end
                        else if (old[i] && x[i]) begin ne++; m_live[i] = 1'b0; end
                    end
                    m_dest = (m_dest + nh > 255) ? 255 : m_dest + nh;
                    m_esc  = (m_esc + ne > 255) ? 255 : m_esc + ne;
                    if (ph == PH_DRAIN) begin
                        slot = 0;
                        for (int i = 0; i < NS; i++) if (old[i]) slot = 1;
                        if (slot == 0) ph = PH_WON;
                    end else if (m_launched == WS) ph = PH_DRAIN;
                    else if (sof) begin
                        if (m_wait > 0) m_wait--;
                        else begin
                            slot = -1;
                            for (int i = 0; i < NS; i++) if (!old[i] && slot < 0) slot = i;
                            if (slot >= 0) begin
                                m_live[slot] = 1'b1;
                                m_y = YM + int'(lfsr_tab[m_launched]);
                                m_launched++;
                                m_wait = SI - 1;
                                exp_q.push_back('{slot: slot, y: m_y});
                            end
                        end
                    end
                end
            end
            default: if (!en) model_clear();
        endcase
    endtask

    task automatic compare();
        check("slot_active", int'(bus.slot_active), live_mask());
        check("destroyed_count", int'(destroyed_count), m_dest);
        check("escaped_count", int'(escaped_count), m_esc);
        check("stage_done", int'(stage_done), int'(ph == PH_WON));
        check("stage_failed", int'(stage_failed), int'(ph == PH_LOST));
        check("spawn_y_hold", int'(bus.spawn_y), m_y);
    endtask

    task automatic step(input bit sof, input bit en, input logic [3:0] h, input logic [3:0] x);
        @(negedge clk);
        startOfFrame = sof; stage_enable = en;
        bus.asteroid_hit = h; bus.asteroid_exited = x;
        model_step(sof, en, h, x);
        @(posedge clk); #1;
        compare();
    endtask

    task automatic quiet(input int n);
        repeat (n) step(1'b0, 1'b1, 4'b0, 4'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        startOfFrame = 1'b0; stage_enable = 1'b0;
        bus.asteroid_hit = '0; bus.asteroid_exited = '0;
        #2 resetN = 1'b0;
        model_clear();
        #1;
        compare();
        check("rst_slot_active", int'(bus.slot_active), 0);
        check("rst_destroyed", int'(destroyed_count), 0);
        @(negedge clk);
        #2 resetN = 1'b1;
    endtask

    // Spawn monitor: every launch the DUT presents is matched against the queue
    initial begin
        spawn_t     e;
        logic [3:0] ep;
        forever begin
            @(negedge clk);
            if (bus.spawn_pulse != 4'b0) begin
                if (exp_q.size() == 0) check("unexpected_spawn", int'(bus.spawn_pulse), 0);
                else begin
                    e  = exp_q.pop_front();
                    ep = 4'b0001 << e.slot;
                    check("spawn_pulse", int'(bus.spawn_pulse), int'(ep));
                    check("spawn_y", int'(bus.spawn_y), e.y);
                end
            end
        end
    end

    initial begin
        logic [7:0] s;
        bit         en_r;
        bit         sof_r;
        logic [3:0] h_r, x_r;

        s = 8'hA5;
        for (int k = 0; k < 256; k++) begin
            lfsr_tab[k] = s;
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end

        resetN = 1'b0; startOfFrame = 1'b0; stage_enable = 1'b0;
        bus.asteroid_hit = '0; bus.asteroid_exited = '0;
        model_clear();
        repeat (3) @(negedge clk);
        compare();
        check("reset_pulse", int'(bus.spawn_pulse), 0);
        #2 resetN = 1'b1;

        // Cadence, deferral, mixed hit/exit and failure
        step(1'b0, 1'b1, 4'b0, 4'b0);
        step(1'b1, 1'b1, 4'b0, 4'b0);
        check("first_pulse", int'(bus.spawn_pulse), 1);
        check("first_y", int'(bus.spawn_y), 197);
        quiet(3);
        repeat (2) begin step(1'b1, 1'b1, 4'b0, 4'b0); quiet(3); end
        step(1'b1, 1'b1, 4'b0, 4'b0);
        check("second_pulse", int'(bus.spawn_pulse), 2);
        check("second_y", int'(bus.spawn_y), 106);
        quiet(3);
        repeat (8) begin step(1'b1, 1'b1, 4'b0, 4'b0); quiet(3); end
        step(1'b1, 1'b1, 4'b0, 4'b0);
        check("deferred_pulse", int'(bus.spawn_pulse), 0);
        check("all_busy", int'(bus.slot_active), 15);
        step(1'b0, 1'b1, 4'b0100, 4'b0);
        check("slot2_freed", int'(bus.slot_active), 11);
        quiet(2);
        step(1'b1, 1'b1, 4'b0, 4'b0);
        check("retry_pulse", int'(bus.spawn_pulse), 4);
        step(1'b0, 1'b1, 4'b1001, 4'b1010);
        check("mixed_destroyed", int'(destroyed_count), 3);
        check("mixed_escaped", int'(escaped_count), 1);
        check("mixed_active", int'(bus.slot_active), 4);
        step(1'b0, 1'b1, 4'b0, 4'b0100);
        step(1'b0, 1'b1, 4'b0, 4'b0);
        check("failed_flag", int'(stage_failed), 1);
        check("failed_active", int'(bus.slot_active), 0);
        step(1'b0, 1'b0, 4'b0, 4'b0);
        check("idle_failed", int'(stage_failed), 0);
        check("idle_escaped", int'(escaped_count), 0);

        // Full wave cleared, inactive pulses ignored, drain to done
        step(1'b0, 1'b1, 4'b0, 4'b0);
        for (int k = 0; k < WS; k++) begin
            step(1'b1, 1'b1, 4'b0, 4'b0);
            if (k < WS - 1) begin
                step(1'b0, 1'b1, 4'b0001, 4'b0);
                quiet(2);
                repeat (2) begin step(1'b1, 1'b1, 4'b0, 4'b0); quiet(3); end
            end
        end
        step(1'b0, 1'b1, 4'b1110, 4'b1110);
        check("inactive_destroyed", int'(destroyed_count), 5);
        check("inactive_escaped", int'(escaped_count), 0);
        step(1'b0, 1'b1, 4'b0001, 4'b0);
        check("last_clear_done", int'(stage_done), 0);
        step(1'b0, 1'b1, 4'b0, 4'b0);
        check("done_flag", int'(stage_done), 1);
        check("done_count", int'(destroyed_count), 6);
        quiet(2);
        step(1'b0, 1'b0, 4'b0, 4'b0);

        // Abort mid-wave and asynchronous reset both restart the sequence
        step(1'b0, 1'b1, 4'b0, 4'b0);
        step(1'b1, 1'b1, 4'b0, 4'b0);
        quiet(3);
        step(1'b1, 1'b1, 4'b0, 4'b0);
        step(1'b0, 1'b0, 4'b0, 4'b0);
        check("abort_active", int'(bus.slot_active), 0);
        step(1'b0, 1'b1, 4'b0, 4'b0);
        step(1'b1, 1'b1, 4'b0, 4'b0);
        check("restart_y", int'(bus.spawn_y), 197);
        quiet(1);
        pulse_reset();
        step(1'b0, 1'b1, 4'b0, 4'b0);
        step(1'b1, 1'b1, 4'b0, 4'b0);
        check("post_reset_y", int'(bus.spawn_y), 197);

        // Random traffic
        en_r = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin pulse_reset(); en_r = 1'b0; end
            if (en_r) begin
                if ((ph == PH_WON || ph == PH_LOST) ? ($urandom_range(0, 7) == 0)
                                                    : ($urandom_range(0, 299) == 0)) en_r = 1'b0;
            end else if ($urandom_range(0, 2) == 0) en_r = 1'b1;
            sof_r = ($urandom_range(0, 2) == 0);
            h_r   = ($urandom_range(0, 3) == 0)  ? 4'($urandom) : 4'b0;
            x_r   = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0;
            step(sof_r, en_r, h_r, x_r);
        end
        step(1'b0, 1'b0, 4'b0, 4'b0);
        @(negedge clk); #1;
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/asteroids_wave_controller.md
# asteroids_wave_controller

Schedules an asteroid wave in the asteroids special stage. Owns a fixed pool of asteroid mover slots, decides when each slot is (re)launched and at what starting row, tracks hits and escapes, and reports stage completion or failure to the game-level state machine. Sits between the stage sequencer (which enables the stage) and the per-slot asteroid movers (which consume its spawn pulses and report hits and border exits).

## Interface
Parameters:
- NUM_SLOTS, 4, number of asteroid mover instances managed (1..8)
- SPAWN_INTERVAL, 45, frames between spawn attempts (1..255)
- WAVE_SIZE, 12, total asteroids launched per wave (1..255)
- MAX_ESCAPES, 3, escapes that fail the stage (1..255)
- Y_MIN, 32, lowest spawn row in pixels
- PIXEL_WIDTH, 11, coordinate width

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- stage_enable  in  1  level; high runs the stage, low aborts or returns to idle
- asteroid_hit  in  NUM_SLOTS  per-slot one-cycle pulse: asteroid destroyed by missile or player
- asteroid_exited  in  NUM_SLOTS  per-slot one-cycle pulse: asteroid left the playfield
- slot_active  out  NUM_SLOTS  slot currently carries a live asteroid
- spawn_pulse  out  NUM_SLOTS  one-hot, one-cycle launch command to a mover
- spawn_y  out  PIXEL_WIDTH  start row for the slot being launched
- destroyed_count  out  8  asteroids hit this wave
- escaped_count  out  8  asteroids escaped this wave
- stage_done  out  1  wave cleared
- stage_failed  out  1  escape limit reached

## Operation
- States: IDLE, RUNNING, DRAINING, DONE, FAILED. Reset -> IDLE; every output 0, frame counter 0, LFSR = 8'hA5.
- IDLE: on stage_enable=1 -> RUNNING; clear counters and spawned count, frame counter = 0.
- RUNNING: on each startOfFrame the frame counter is examined. If 0, a spawn attempt occurs and the counter reloads with SPAWN_INTERVAL-1. Otherwise it decrements.
- A spawn attempt selects the lowest-index slot with slot_active=0 (registered value). If found: set that slot_active bit, pulse the matching spawn_pulse bit, set spawn_y = Y_MIN + LFSR, advance LFSR, increment spawned count. If none is free, the attempt is deferred: the counter holds at 0 and the attempt is retried on every following startOfFrame.
- LFSR: 8-bit Fibonacci, shift left, new bit0 = b7^b5^b4^b3. Advances only on a successful spawn.
- spawned count == WAVE_SIZE -> DRAINING. No further spawns occur.
- Hit on an active slot: clear the bit, destroyed_count += popcount. Exit on an active slot: clear the bit, escaped_count += popcount. Hit and exit on the same slot in the same cycle count as a hit only. Pulses on inactive slots are ignored. Multiple bits in one cycle are all counted.
- DRAINING: when slot_active == 0 -> DONE.
- escaped_count >= MAX_ESCAPES in RUNNING or DRAINING -> FAILED. FAILED takes priority over DONE in the same cycle, and slot_active is cleared.
- DONE/FAILED: stage_done/stage_failed is held high until stage_enable=0, then the block returns to IDLE.
- stage_enable=0 in RUNNING/DRAINING: abort to IDLE, clear slot_active and all counters. Asynchronous reset mid-wave has the same effect immediately.

## Timing
- All outputs are registered. spawn_pulse and spawn_y update in the cycle after the startOfFrame edge. spawn_y holds until the next spawn.
- A slot freed by hit or exit in cycle t is eligible for spawn from cycle t+1. A spawn never targets a slot being cleared in the same cycle.
- Counters saturate at 255. stage_done/stage_failed rise one cycle after the qualifying condition.
- Spawn spacing is exactly SPAWN_INTERVAL frames when slots are free. The first spawn occurs on the first startOfFrame after entering RUNNING.

## Structure
- Package asteroids_pkg: wave_state_t enum, LFSR_SEED, LFSR tap constant, counter width constant.
- Sub-module asteroid_slot_picker (combinational): free mask in -> found flag, one-hot select, index.

## Test plan
Configuration: NUM_SLOTS=4, SPAWN_INTERVAL=3, WAVE_SIZE=6, MAX_ESCAPES=2, Y_MIN=32.
- Reset, then stage_enable=1 and first startOfFrame -> spawn_pulse=4'b0001, spawn_y=197. Second spawn (frame 4) -> 4'b0010, spawn_y=106.
- No hits -> spawns on frames 1, 4, 7, 10 to slots 0..3. Frame 13 -> no pulse (deferred). Hit slot 2 -> next startOfFrame spawns slot 2.
- In the same cycle: hit[0], exited[1], hit[3] and exited[3] -> destroyed_count +2, escaped_count +1, slot_active bits 0, 1, 3 cleared.
- Second escape -> stage_failed=1, slot_active=0. Drop stage_enable -> IDLE, all outputs 0.
- All 6 asteroids spawned and hit -> DRAINING, then stage_done=1 one cycle after the last slot clears. Pulses on inactive slots leave the counters unchanged.
- Drop stage_enable mid-RUNNING, or assert resetN low mid-wave -> slot_active=0, counters 0, the next enable restarts with spawn_y=197.
